// File: rtl/capture_pkg.sv
// Shared definitions for the per-channel capture sequencer:
// FSM state encoding and default address widths.
package capture_pkg;

    localparam int CAP_ADDR_WIDTH     = 13;
    localparam int CAP_RAM_ADDR_WIDTH = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/capture_addr_mux.sv
// RAM address selection: the capture write pointer or a readout index
// rebased onto the oldest sample of the frozen buffer.
module capture_addr_mux
    import capture_pkg::*;
#(
    parameter int ADDR_WIDTH     = CAP_ADDR_WIDTH,
    parameter int RAM_ADDR_WIDTH = CAP_RAM_ADDR_WIDTH
) (
    input  logic                      i_rd_sel,
    input  logic [ADDR_WIDTH-1:0]     i_wr_ptr,
    input  logic [ADDR_WIDTH-1:0]     i_start_addr,
    input  logic [ADDR_WIDTH-1:0]     i_rd_addr,
    output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr
);

    logic [ADDR_WIDTH-1:0] w_rd_phys;
    logic [ADDR_WIDTH-1:0] w_sel_addr;

    // Natural ADDR_WIDTH wrap gives the circular rebase for free.
    assign w_rd_phys  = i_start_addr + i_rd_addr;
    assign w_sel_addr = i_rd_sel ? w_rd_phys : i_wr_ptr;
    assign o_ram_addr = {{(RAM_ADDR_WIDTH-ADDR_WIDTH){1'b0}}, w_sel_addr};

endmodule

// File: rtl/capture_sequencer.sv
// One-channel capture sequencer: circular pre-trigger capture, counted
// post-trigger fill, freeze, and oldest-first readout of the sample RAM.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int ADDR_WIDTH     = CAP_ADDR_WIDTH,
    parameter int RAM_ADDR_WIDTH = CAP_RAM_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arm,
    input  logic                      abort,
    input  logic                      sample_valid,
    input  logic                      sample_in,
    input  logic                      trigger,
    input  logic [ADDR_WIDTH-1:0]     post_count,
    input  logic                      rd_req,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      ram_we,
    output logic                      ram_data,
    input  logic                      ram_q,
    output logic                      rd_data,
    output logic                      rd_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      wrapped,
    output logic [ADDR_WIDTH-1:0]     trig_addr
);

    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = {ADDR_WIDTH{1'b1}};

    cap_state_t            r_state;
    cap_state_t            w_next_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_post_cnt;
    logic [ADDR_WIDTH-1:0] r_post_len;
    logic [ADDR_WIDTH-1:0] r_start_addr;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic                  r_wrapped;
    logic                  r_rd_valid;

    logic                  w_arm_go;
    logic                  w_wr_en;
    logic                  w_trig_hit;
    logic                  w_finish;
    logic                  w_wrap_now;
    logic                  w_rd_accept;
    logic [ADDR_WIDTH-1:0] w_eff_post;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A zero post-trigger length behaves as one: keep just the trigger sample.
    assign w_eff_post = (r_post_len == '0) ? ONE : r_post_len;

    always_comb begin
        w_next_state = r_state;
        w_arm_go     = 1'b0;
        w_wr_en      = 1'b0;
        w_trig_hit   = 1'b0;
        w_finish     = 1'b0;
        w_rd_accept  = 1'b0;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        w_arm_go     = 1'b1;
                        w_next_state = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        w_wr_en = 1'b1;
                        if (trigger) begin
                            w_trig_hit = 1'b1;
                            if (w_eff_post <= ONE) begin
                                w_finish     = 1'b1;
                                w_next_state = ST_DONE;
                            end else begin
                                w_next_state = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (sample_valid) begin
                        w_wr_en = 1'b1;
                        if (r_post_cnt == ONE) begin
                            w_finish     = 1'b1;
                            w_next_state = ST_DONE;
                        end
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
        // Readout only touches the RAM port while no capture owns it.
        if (rd_req && (r_state == ST_IDLE || r_state == ST_DONE)) begin
            w_rd_accept = 1'b1;
        end
    end

    assign w_wrap_now = r_wrapped
                      | ((r_state == ST_CAPTURE) && w_wr_en && (r_wr_ptr == PTR_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_post_cnt   <= '0;
            r_post_len   <= '0;
            r_start_addr <= '0;
            r_trig_addr  <= '0;
            r_wrapped    <= 1'b0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_arm_go) begin
                r_wr_ptr   <= '0;
                r_wrapped  <= 1'b0;
                r_post_len <= post_count;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ONE;
                if (r_state == ST_CAPTURE && r_wr_ptr == PTR_MAX) begin
                    r_wrapped <= 1'b1;
                end
                if (r_state == ST_POST) begin
                    r_post_cnt <= r_post_cnt - ONE;
                end
            end
            if (w_trig_hit) begin
                r_trig_addr <= r_wr_ptr;
                r_post_cnt  <= w_eff_post - ONE;
            end
            // Oldest sample sits just past the final write once the ring has filled.
            if (w_finish) begin
                r_start_addr <= w_wrap_now ? (r_wr_ptr + ONE) : '0;
            end
        end
    end

    capture_addr_mux #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
    ) u_addr_mux (
        .i_rd_sel     (w_rd_accept),
        .i_wr_ptr     (r_wr_ptr),
        .i_start_addr (r_start_addr),
        .i_rd_addr    (rd_addr),
        .o_ram_addr   (ram_addr)
    );

    assign ram_we    = w_wr_en;
    assign ram_data  = sample_in;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_valid & ram_q;
    assign busy      = (r_state == ST_CAPTURE) || (r_state == ST_POST);
    assign done      = (r_state == ST_DONE);
    assign wrapped   = r_wrapped;
    assign trig_addr = r_trig_addr;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a behavioural 8K x 1 RAM
// (registered read address) attached to the RAM port.
module tb_capture_sequencer;

    localparam int AW    = 13;
    localparam int RAW   = 14;
    localparam int DEPTH = 8192;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           arm = 1'b0;
    logic           abort = 1'b0;
    logic           sample_valid = 1'b0;
    logic           sample_in = 1'b0;
    logic           trigger = 1'b0;
    logic [AW-1:0]  post_count = '0;
    logic           rd_req = 1'b0;
    logic [AW-1:0]  rd_addr = '0;
    logic [RAW-1:0] ram_addr;
    logic           ram_we;
    logic           ram_data;
    logic           ram_q;
    logic           rd_data;
    logic           rd_valid;
    logic           busy;
    logic           done;
    logic           wrapped;
    logic [AW-1:0]  trig_addr;

    int n_vec = 0;
    int n_bad = 0;

    logic          mem [DEPTH];
    logic [AW-1:0] ram_raddr_q = '0;

    capture_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .abort        (abort),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .trigger      (trigger),
        .post_count   (post_count),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_data     (ram_data),
        .ram_q        (ram_q),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .done         (done),
        .wrapped      (wrapped),
        .trig_addr    (trig_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[AW-1:0]] <= ram_data;
        ram_raddr_q <= ram_addr[AW-1:0];
    end
    assign ram_q = mem[ram_raddr_q];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic s, input logic t);
        sample_valid = 1'b1;
        sample_in    = s;
        trigger      = t;
        tick();
        sample_valid = 1'b0;
        sample_in    = 1'b0;
        trigger      = 1'b0;
    endtask

    task automatic do_arm(input logic [AW-1:0] pc);
        post_count = pc;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic rd_one(input string tag, input logic [AW-1:0] a,
                          input int exp_phys, input logic exp_d);
        rd_req  = 1'b1;
        rd_addr = a;
        #1;
        chk({tag, "_addr"}, 32'(ram_addr), exp_phys);
        tick();
        rd_req = 1'b0;
        chk({tag, "_vld"}, 32'(rd_valid), 1);
        chk({tag, "_data"}, 32'(rd_data), 32'(exp_d));
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wrapped", 32'(wrapped), 0);
        chk("rst_trig", 32'(trig_addr), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_rdvld", 32'(rd_valid), 0);
        chk("rst_rddata", 32'(rd_data), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        rst_n = 1'b1;
        tick();

        // No wrap: 1010101010, trigger on sample 6, post_count 4
        do_arm(13'd4);
        chk("nw_busy", 32'(busy), 1);
        for (int k = 1; k <= 10; k++) begin
            sample_valid = 1'b1;
            sample_in    = (k % 2 == 1);
            trigger      = (k == 6);
            #1;
            if (k == 1) begin
                chk("nw_we1", 32'(ram_we), 1);
                chk("nw_addr1", 32'(ram_addr), 0);
                chk("nw_data1", 32'(ram_data), 1);
            end
            if (k == 10) chk("nw_we_after_done", 32'(ram_we), 0);
            tick();
            sample_valid = 1'b0;
            trigger      = 1'b0;
            if (k == 8) chk("nw_notdone8", 32'(done), 0);
            if (k == 9) begin
                chk("nw_done", 32'(done), 1);
                chk("nw_busy9", 32'(busy), 0);
                chk("nw_trig", 32'(trig_addr), 5);
                chk("nw_wrapped", 32'(wrapped), 0);
            end
        end
        // Back-to-back readout 0..8
        for (int i = 0; i < 9; i++) begin
            rd_req  = 1'b1;
            rd_addr = AW'(i);
            #1;
            chk("nw_rd_addr", 32'(ram_addr), i);
            tick();
            chk("nw_rd_vld", 32'(rd_valid), 1);
            chk("nw_rd_data", 32'(rd_data), (i % 2 == 0) ? 1 : 0);
        end
        rd_req = 1'b0;
        tick();
        chk("nw_rd_idle", 32'(rd_valid), 0);

        // Wrap: 9000 samples of addr[0], trigger at sample 8500, post_count 100
        do_arm(13'd100);
        for (int k = 1; k <= 9000; k++) begin
            sample_valid = 1'b1;
            sample_in    = ((k - 1) % DEPTH) % 2 == 1;
            trigger      = (k == 8500);
            if (k == 10) begin
                rd_req  = 1'b1;
                rd_addr = 13'd5;
            end
            #1;
            if (k == 10) begin
                chk("gate_addr", 32'(ram_addr), 9);
                chk("gate_we", 32'(ram_we), 1);
            end
            tick();
            rd_req = 1'b0;
            if (k == 10) chk("gate_rdvld", 32'(rd_valid), 0);
        end
        sample_valid = 1'b0;
        trigger      = 1'b0;
        chk("wr_done", 32'(done), 1);
        chk("wr_wrapped", 32'(wrapped), 1);
        chk("wr_trig", 32'(trig_addr), 307);
        rd_one("wr_rd0", 13'd0, 407, 1'b1);
        rd_one("wr_rd1", 13'd1, 408, 1'b0);
        rd_one("wr_rdlast", 13'd8191, 406, 1'b0);

        // post_count = 0: trigger sample only
        do_arm(13'd0);
        chk("pc0_busy", 32'(busy), 1);
        chk("pc0_wrapped", 32'(wrapped), 0);
        sample_valid = 1'b1;
        sample_in    = 1'b1;
        trigger      = 1'b1;
        #1;
        chk("pc0_we", 32'(ram_we), 1);
        chk("pc0_addr", 32'(ram_addr), 0);
        tick();
        trigger = 1'b0;
        chk("pc0_done", 32'(done), 1);
        chk("pc0_trig", 32'(trig_addr), 0);
        #1;
        chk("pc0_we_after", 32'(ram_we), 0);
        tick();
        sample_valid = 1'b0;
        sample_in    = 1'b0;
        rd_one("pc0_rd0", 13'd0, 0, 1'b1);

        // Abort in POST with post_cnt 50; arm while busy is ignored
        do_arm(13'd100);
        put(1'b1, 1'b1);
        for (int k = 0; k < 48; k++) put(1'b0, 1'b0);
        arm          = 1'b1;
        sample_valid = 1'b1;
        #1;
        chk("busy_arm_addr", 32'(ram_addr), 49);
        tick();
        arm          = 1'b0;
        chk("busy_arm_busy", 32'(busy), 1);
        abort = 1'b1;
        #1;
        chk("abort_we", 32'(ram_we), 0);
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        #1;
        chk("abort_we_idle", 32'(ram_we), 0);
        tick();
        sample_valid = 1'b0;

        // abort + arm together in DONE
        do_arm(13'd1);
        put(1'b0, 1'b1);
        chk("aa_done_pre", 32'(done), 1);
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        chk("aa_busy", 32'(busy), 0);
        chk("aa_done", 32'(done), 0);

        // Asynchronous reset mid-capture
        do_arm(13'd100);
        put(1'b0, 1'b0);
        put(1'b0, 1'b0);
        put(1'b1, 1'b1);
        chk("rm_trig_pre", 32'(trig_addr), 2);
        chk("rm_busy_pre", 32'(busy), 1);
        sample_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_busy", 32'(busy), 0);
        chk("rm_trig", 32'(trig_addr), 0);
        chk("rm_we", 32'(ram_we), 0);
        chk("rm_done", 32'(done), 0);
        sample_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
